// File: rtl/data_memory_if.sv
// data_memory_if: load/store bus between the memory stage and the data memory
interface data_memory_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] read_data;
  modport master (output address, write_data, mem_read, mem_write, input read_data);
  modport slave (input address, write_data, mem_read, mem_write, output read_data);
endinterface

// File: rtl/data_memory.sv
// data_memory: 64 x 64-bit word-addressed memory, edge-committed writes and combinational gated reads
module data_memory #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input logic         clk,
  input logic         reset,
  data_memory_if.slave bus
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH] = '{default: '0};
  // reset clears every word and drops any write requested in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
    end else if (bus.mem_write) begin
      mem[bus.address] <= bus.write_data;
    end
  end
  // loads see the stored array only; write_data is never bypassed
  always_comb bus.read_data = bus.mem_read ? mem[bus.address] : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory
module tb_data_memory;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  data_memory_if bus ();
  data_memory dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] a, input logic [63:0] wd, input logic r, input logic w);
    bus.address = a;
    bus.write_data = wd;
    bus.mem_read = r;
    bus.mem_write = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(6'd0, 64'h0, 1'b1, 1'b0);
    #1;
    tests++;
    if (bus.read_data !== 64'h0) begin fails++; $display("FAIL init_addr0 got=%h exp=%h", bus.read_data, 64'h0); end
    drive(6'd63, 64'h0, 1'b1, 1'b0);
    #1;
    tests++;
    if (bus.read_data !== 64'h0) begin fails++; $display("FAIL init_addr63 got=%h exp=%h", bus.read_data, 64'h0); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(6'd10, 64'h0, 1'b1, 1'b0);
    #1;
    tests++;
    if (bus.read_data !== 64'h0) begin fails++; $display("FAIL post_reset got=%h exp=%h", bus.read_data, 64'h0); end
  endtask

  task automatic test_write_read();
    logic [63:0] v [3] = '{64'hDEADBEEF12345678, 64'hCAFEBABE87654321, 64'h123456789ABCDEF0};
    for (int i = 0; i < 3; i++) begin
      drive(6'(i), v[i], 1'b0, 1'b1);
      #1;
      tests++;
      if (bus.read_data !== 64'h0) begin fails++; $display("FAIL wr_gated[%0d] got=%h exp=%h", i, bus.read_data, 64'h0); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(6'(i), 64'h0, 1'b1, 1'b0);
      #1;
      tests++;
      if (bus.read_data !== v[i]) begin fails++; $display("FAIL readback[%0d] got=%h exp=%h", i, bus.read_data, v[i]); end
    end
  endtask

  task automatic test_pair();
    drive(6'd3, 64'hAABBCCDDEEFF0011, 1'b0, 1'b1);
    #1;
    tests++;
    if (bus.read_data !== 64'h0) begin fails++; $display("FAIL pair_wr got=%h exp=%h", bus.read_data, 64'h0); end
    tick();
    drive(6'd3, 64'h0, 1'b1, 1'b0);
    #1;
    tests++;
    if (bus.read_data !== 64'hAABBCCDDEEFF0011) begin fails++; $display("FAIL pair_rd got=%h exp=%h", bus.read_data, 64'hAABBCCDDEEFF0011); end
  endtask

  task automatic test_gating();
    drive(6'd3, 64'h0, 1'b0, 1'b0);
    #1;
    tests++;
    if (bus.read_data !== 64'h0) begin fails++; $display("FAIL gate_off got=%h exp=%h", bus.read_data, 64'h0); end
    bus.mem_read = 1'b1;
    #1;
    tests++;
    if (bus.read_data !== 64'hAABBCCDDEEFF0011) begin fails++; $display("FAIL gate_on got=%h exp=%h", bus.read_data, 64'hAABBCCDDEEFF0011); end
    tick();
    drive(6'd1, 64'h0, 1'b0, 1'b0);
    tick();
    bus.mem_read = 1'b1;
    #1;
    tests++;
    if (bus.read_data !== 64'hCAFEBABE87654321) begin fails++; $display("FAIL idle_hold got=%h exp=%h", bus.read_data, 64'hCAFEBABE87654321); end
  endtask

  task automatic test_overwrite();
    drive(6'd63, 64'h1, 1'b0, 1'b1);
    tick();
    drive(6'd63, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
    tick();
    drive(6'd63, 64'h0, 1'b1, 1'b0);
    #1;
    tests++;
    if (bus.read_data !== 64'hFFFFFFFFFFFFFFFF) begin fails++; $display("FAIL ovw_63 got=%h exp=%h", bus.read_data, 64'hFFFFFFFFFFFFFFFF); end
    bus.address = 6'd62;
    #1;
    tests++;
    if (bus.read_data !== 64'h0) begin fails++; $display("FAIL ovw_62 got=%h exp=%h", bus.read_data, 64'h0); end
    bus.address = 6'd0;
    #1;
    tests++;
    if (bus.read_data !== 64'hDEADBEEF12345678) begin fails++; $display("FAIL ovw_0 got=%h exp=%h", bus.read_data, 64'hDEADBEEF12345678); end
  endtask

  task automatic test_back_to_back();
    drive(6'd5, 64'h11, 1'b0, 1'b1);
    tick();
    drive(6'd5, 64'h22, 1'b1, 1'b1);
    #1;
    tests++;
    if (bus.read_data !== 64'h11) begin fails++; $display("FAIL rw_before got=%h exp=%h", bus.read_data, 64'h11); end
    tick();
    tests++;
    if (bus.read_data !== 64'h22) begin fails++; $display("FAIL rw_after got=%h exp=%h", bus.read_data, 64'h22); end
    bus.mem_write = 1'b0;
  endtask

  task automatic test_reset_drop();
    logic [63:0] v [4] = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    for (int i = 0; i < 4; i++) begin
      drive(6'(i), v[i], 1'b0, 1'b1);
      tick();
    end
    drive(6'd2, 64'h0, 1'b1, 1'b0);
    #1;
    tests++;
    if (bus.read_data !== 64'hA2) begin fails++; $display("FAIL fill_2 got=%h exp=%h", bus.read_data, 64'hA2); end
    drive(6'd0, 64'h55, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(6'(i), 64'h0, 1'b1, 1'b0);
      #1;
      tests++;
      if (bus.read_data !== 64'h0) begin fails++; $display("FAIL rst_clr[%0d] got=%h exp=%h", i, bus.read_data, 64'h0); end
    end
    bus.address = 6'd63;
    #1;
    tests++;
    if (bus.read_data !== 64'h0) begin fails++; $display("FAIL rst_clr63 got=%h exp=%h", bus.read_data, 64'h0); end
  endtask

  initial begin
    drive(6'd0, 64'h0, 1'b0, 1'b0);
    test_reset();
    test_write_read();
    test_pair();
    test_gating();
    test_overwrite();
    test_back_to_back();
    test_reset_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
